// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W[0..ROUNDS-1]
// to the round datapath over a valid/ready handshake, generating W[16..] in a
// 16-word sliding window.
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [511:0]     block,
  input  logic             w_ready,
  output logic [31:0]      w_out,
  output logic [IDX_W-1:0] round_idx,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN    = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [WORD_W-1:0] win [WIN];
  logic              accept_c;
  logic              last_c;
  logic              load_c;
  logic              shift_c;
  logic [WORD_W-1:0] next_w_c;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next generated word, taken from the registered window only.
  always_comb begin
    next_w_c = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  end

  // Next-state decode plus window load/shift enables.
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    accept_c   = w_valid & w_ready;
    last_c     = (round_idx == IDX_W'(ROUNDS - 1));
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (accept_c) begin
          if (last_c) begin
            next_state = DONE;
          end else begin
            shift_c = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered status flags, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      w_valid <= (next_state == RUN);
      busy    <= (next_state == RUN);
      done    <= (next_state == DONE);
    end
  end

  // Round index: cleared on load, advanced on every non-final accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_idx <= '0;
    end else if (load_c) begin
      round_idx <= '0;
    end else if (shift_c) begin
      round_idx <= round_idx + IDX_W'(1);
    end
  end

  // Sliding window: parallel load of the block, or shift down appending W[t+16].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) begin
        win[i] <= '0;
      end
    end else if (load_c) begin
      for (int i = 0; i < WIN; i++) begin
        win[i] <= block[511 - 32*i -: 32];
      end
    end else if (shift_c) begin
      for (int i = 0; i < WIN - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[WIN-1] <= next_w_c;
    end
  end

  assign w_out = win[0];

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: a 64-round and a 16-round instance share inputs;
// words are checked against a FIPS 180-4 schedule computed in plain arithmetic.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] block;
  logic         w_ready;

  logic [31:0]  w_out64;
  logic [5:0]   round_idx64;
  logic         w_valid64, busy64, done64;

  logic [31:0]  w_out16;
  logic [3:0]   round_idx16;
  logic         w_valid16, busy16, done16;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_w [64];
  logic [31:0] dut_w [64];

  sha256_msg_schedule #(.ROUNDS(64), .IDX_W(6)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start), .block(block), .w_ready(w_ready),
    .w_out(w_out64), .round_idx(round_idx64), .w_valid(w_valid64),
    .busy(busy64), .done(done64)
  );

  sha256_msg_schedule #(.ROUNDS(16), .IDX_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .block(block), .w_ready(w_ready),
    .w_out(w_out16), .round_idx(round_idx16), .w_valid(w_valid16),
    .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the FIPS 180-4 recurrence.
  task automatic build_ref(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) ref_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(ref_w[i-15], 7) ^ rr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
      s1 = rr(ref_w[i-2], 17) ^ rr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
      ref_w[i] = s1 + ref_w[i-7] + s0 + ref_w[i-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Runs one block through the 64-round instance and checks every emitted word.
  task automatic run_block(input logic [511:0] blk, input int rdy_pct,
                           input int stall_idx, input int stall_len,
                           input bit poke_start, input logic [511:0] poke_blk,
                           input bit start_in_done, output int cycles);
    int exp, stall_cnt;
    bit prev_stall, got_done, poked;
    logic [31:0] prev_w;
    logic [5:0]  prev_idx;
    build_ref(blk);
    @(negedge clk);
    start = 1'b1; block = blk; w_ready = 1'b0;
    exp = 0; cycles = 0; stall_cnt = 0; prev_stall = 0; got_done = 0; poked = 0;
    prev_w = '0; prev_idx = '0;
    while (!got_done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (exp == 64) begin
        checks++;
        if (done64 !== 1'b1 || w_valid64 !== 1'b0 || busy64 !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: got done=%b valid=%b busy=%b required 1 0 0", done64, w_valid64, busy64);
        end
        got_done = 1;
        if (start_in_done) begin
          start = 1'b1; block = rand_block();
        end
      end else begin
        checks++;
        if (w_valid64 !== 1'b1 || busy64 !== 1'b1 || done64 !== 1'b0) begin
          errors++;
          $display("FAIL run_flags t=%0d: got valid=%b busy=%b done=%b required 1 1 0", exp, w_valid64, busy64, done64);
        end
        checks++;
        if (round_idx64 !== 6'(exp)) begin
          errors++;
          $display("FAIL round_idx: got %0d required %0d", round_idx64, exp);
        end
        checks++;
        if (w_out64 !== ref_w[exp]) begin
          errors++;
          $display("FAIL w_out t=%0d: got %h required %h", exp, w_out64, ref_w[exp]);
        end
        if (prev_stall) begin
          checks++;
          if (w_out64 !== prev_w || round_idx64 !== prev_idx) begin
            errors++;
            $display("FAIL stall_hold: got %h/%0d required %h/%0d", w_out64, round_idx64, prev_w, prev_idx);
          end
        end
        dut_w[exp] = w_out64;
        if (exp == stall_idx && stall_cnt < stall_len) begin
          w_ready = 1'b0;
          stall_cnt++;
        end else begin
          w_ready = ($urandom_range(99) < rdy_pct);
        end
        if (poke_start && !poked && exp == 10) begin
          start = 1'b1; block = poke_blk; poked = 1;
        end
        prev_stall = !w_ready;
        prev_w = w_out64;
        prev_idx = round_idx64;
        if (w_ready) exp++;
      end
    end
    if (!got_done) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d words required 64", exp);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b0; w_ready = 1'b0;
      checks++;
      if (done64 !== 1'b0 || w_valid64 !== 1'b0 || busy64 !== 1'b0) begin
        errors++;
        $display("FAIL after_done%0d: got done=%b valid=%b busy=%b required 0 0 0", k, done64, w_valid64, busy64);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({w_out64, round_idx64, w_valid64, busy64, done64,
         w_out16, round_idx16, w_valid16, busy16, done16} !== '0) begin
      errors++;
      $display("FAIL %s: got w64=%h i64=%0d v=%b b=%b d=%b w16=%h i16=%0d v=%b b=%b d=%b required all 0",
               tag, w_out64, round_idx64, w_valid64, busy64, done64,
               w_out16, round_idx16, w_valid16, busy16, done16);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom); w_ready = 1'($urandom); block = rand_block();
      check_all_zero("reset_hold");
    end
    @(negedge clk);
    start = 1'b0; w_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_abc();
    int cyc;
    logic [511:0] abc;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    run_block(abc, 100, -1, 0, 1'b0, '0, 1'b0, cyc);
    checks++;
    if (dut_w[0] !== 32'h61626380) begin errors++; $display("FAIL abc_w0: got %h required 61626380", dut_w[0]); end
    checks++;
    if (dut_w[15] !== 32'h00000018) begin errors++; $display("FAIL abc_w15: got %h required 00000018", dut_w[15]); end
    checks++;
    if (dut_w[16] !== 32'h61626380) begin errors++; $display("FAIL abc_w16: got %h required 61626380", dut_w[16]); end
    checks++;
    if (dut_w[17] !== 32'h000f0000) begin errors++; $display("FAIL abc_w17: got %h required 000f0000", dut_w[17]); end
    checks++;
    if (cyc !== 65) begin errors++; $display("FAIL abc_cycles: got %0d required 65", cyc); end
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 4; n++) run_block(rand_block(), 50, -1, 0, 1'b0, '0, 1'b0, cyc);
  endtask

  task automatic test_start_ignored();
    int cyc;
    logic [511:0] b1, b2;
    b1 = rand_block(); b2 = rand_block();
    run_block(b1, 70, -1, 0, 1'b1, b2, 1'b0, cyc);
    run_block(b2, 100, -1, 0, 1'b0, '0, 1'b0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_block(rand_block(), 100, -1, 0, 1'b0, '0, 1'b1, cyc);
    run_block(rand_block(), 100, -1, 0, 1'b0, '0, 1'b0, cyc);
  endtask

  task automatic test_stall();
    int cyc;
    run_block(rand_block(), 100, 15, 20, 1'b0, '0, 1'b0, cyc);
    checks++;
    if (cyc !== 85) begin errors++; $display("FAIL stall_cycles: got %0d required 85", cyc); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; block = rand_block(); w_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy64 !== 1'b1 || w_valid64 !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_pre: got busy=%b valid=%b required 1 1", busy64, w_valid64);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_run_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("mid_run_after");
    end
    w_ready = 1'b0;
  endtask

  task automatic test_rounds16();
    int waited;
    logic [511:0] b;
    waited = 0;
    w_ready = 1'b1; start = 1'b0;
    while ((busy64 || busy16 || done64 || done16) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    b = rand_block();
    build_ref(b);
    @(negedge clk);
    start = 1'b1; block = b; w_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (w_valid16 !== 1'b1 || round_idx16 !== 4'(t) || w_out16 !== ref_w[t]) begin
        errors++;
        $display("FAIL r16_word t=%0d: got v=%b idx=%0d w=%h required 1 %0d %h",
                 t, w_valid16, round_idx16, w_out16, t, ref_w[t]);
      end
    end
    @(negedge clk);
    checks++;
    if (done16 !== 1'b1 || w_valid16 !== 1'b0) begin
      errors++;
      $display("FAIL r16_done: got done=%b valid=%b required 1 0", done16, w_valid16);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done16 !== 1'b0 || w_valid16 !== 1'b0 || busy16 !== 1'b0) begin
        errors++;
        $display("FAIL r16_idle: got done=%b valid=%b busy=%b required 0 0 0", done16, w_valid16, busy16);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; block = '0;
    test_reset();
    test_abc();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_rounds16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
